// File: rtl/bp_pkg.sv
`default_nettype none
// bp_pkg: shared types, counter reset value and saturating helpers for branch_predictor. Rev 1.0
package bp_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bp_ctr_t;

  // Width-independent per-entry state; tag and target are sized by the module parameters.
  typedef struct packed {
    logic    valid;
    bp_ctr_t ctr;
    logic    is_jump;
  } bp_entry_t;

  localparam bp_ctr_t BP_CTR_RESET = WEAK_NT;

  function automatic bp_ctr_t ctr_inc(input bp_ctr_t c);
    return (c == STRONG_T) ? STRONG_T : bp_ctr_t'(c + 2'd1);
  endfunction

  function automatic bp_ctr_t ctr_dec(input bp_ctr_t c);
    return (c == STRONG_NT) ? STRONG_NT : bp_ctr_t'(c - 2'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_stats_counter.sv
`default_nettype none
// bp_stats_counter: 32-bit event counter that saturates at all-ones. Rev 1.0
module bp_stats_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// branch_predictor: direct-mapped BTB with 2-bit counters, combinational fetch lookup, registered E update.
// Define BP_STATS_EN to add the Stat_Resolved / Stat_Mispredict counters. Rev 1.0
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int TAG_BITS = 8,
  parameter int XLEN     = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [XLEN-1:0] PC_F,
  output logic            Predict_Taken_F,
  output logic [XLEN-1:0] Predict_Target_F,
  input  logic            Update_En_E,
  input  logic            Jump_En_E,
  input  logic [XLEN-1:0] PC_E,
  input  logic            Branch_Taken_E,
  input  logic [XLEN-1:0] PC_Target_E,
  input  logic            Predict_Taken_E
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     Stat_Resolved,
  output logic [31:0]     Stat_Mispredict
`endif
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_LO   = IDX_BITS + 2;
  localparam int TAG_HI   = IDX_BITS + TAG_BITS + 1;

  if ((ENTRIES < 2) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_bad_entries
    $error("branch_predictor: ENTRIES must be a power of 2 and at least 2");
  end
  if (TAG_HI > XLEN - 1) begin : g_bad_tag
    $error("branch_predictor: index and tag fields exceed the PC width");
  end

  bp_entry_t           entry_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];

  logic [IDX_BITS-1:0] f_idx;
  logic [TAG_BITS-1:0] f_tag;
  logic                f_hit;
  logic [IDX_BITS-1:0] e_idx;
  logic [TAG_BITS-1:0] e_tag;
  logic                e_hit;

  assign f_idx = PC_F[IDX_BITS+1:2];
  assign f_tag = PC_F[TAG_HI:TAG_LO];
  assign f_hit = entry_q[f_idx].valid && (tag_q[f_idx] == f_tag);

  assign Predict_Taken_F  = f_hit && (entry_q[f_idx].is_jump || entry_q[f_idx].ctr[1]);
  assign Predict_Target_F = Predict_Taken_F ? target_q[f_idx] : '0;

  assign e_idx = PC_E[IDX_BITS+1:2];
  assign e_tag = PC_E[TAG_HI:TAG_LO];
  assign e_hit = entry_q[e_idx].valid && (tag_q[e_idx] == e_tag);

  // Lookups read the array directly, so a same-cycle write is only seen next cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_q[i]  <= '{valid: 1'b0, ctr: BP_CTR_RESET, is_jump: 1'b0};
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (Update_En_E) begin
      if (Jump_En_E) begin
        entry_q[e_idx]  <= '{valid: 1'b1, ctr: STRONG_T, is_jump: 1'b1};
        tag_q[e_idx]    <= e_tag;
        target_q[e_idx] <= PC_Target_E;
      end else if (Branch_Taken_E) begin
        entry_q[e_idx]  <= '{valid: 1'b1,
                             ctr: e_hit ? ctr_inc(entry_q[e_idx].ctr) : WEAK_T,
                             is_jump: 1'b0};
        tag_q[e_idx]    <= e_tag;
        target_q[e_idx] <= PC_Target_E;
      end else if (e_hit) begin
        entry_q[e_idx].ctr <= ctr_dec(entry_q[e_idx].ctr);
      end
    end
  end

  // Low PC bits and bits above the tag field take no part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PC_F, PC_E};

`ifdef BP_STATS_EN
  bp_stats_counter u_stat_resolved (
    .clk   (CLK),
    .rst   (RST),
    .inc   (Update_En_E),
    .count (Stat_Resolved)
  );

  bp_stats_counter u_stat_mispredict (
    .clk   (CLK),
    .rst   (RST),
    .inc   (Update_En_E && (Predict_Taken_E != Branch_Taken_E)),
    .count (Stat_Mispredict)
  );
`else
  logic unused_predict_e;
  assign unused_predict_e = Predict_Taken_E;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// tb_branch_predictor: directed stimulus with a scoreboard queue checked by a negedge monitor.
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] PC_F = '0;
  logic        Predict_Taken_F;
  logic [31:0] Predict_Target_F;
  logic        Update_En_E = 1'b0;
  logic        Jump_En_E = 1'b0;
  logic [31:0] PC_E = '0;
  logic        Branch_Taken_E = 1'b0;
  logic [31:0] PC_Target_E = '0;
  logic        Predict_Taken_E = 1'b0;
`ifdef BP_STATS_EN
  logic [31:0] Stat_Resolved;
  logic [31:0] Stat_Mispredict;
`endif

  branch_predictor #(.ENTRIES(16), .TAG_BITS(8), .XLEN(32)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .PC_F             (PC_F),
    .Predict_Taken_F  (Predict_Taken_F),
    .Predict_Target_F (Predict_Target_F),
    .Update_En_E      (Update_En_E),
    .Jump_En_E        (Jump_En_E),
    .PC_E             (PC_E),
    .Branch_Taken_E   (Branch_Taken_E),
    .PC_Target_E      (PC_Target_E),
    .Predict_Taken_E  (Predict_Taken_E)
`ifdef BP_STATS_EN
    ,
    .Stat_Resolved    (Stat_Resolved),
    .Stat_Mispredict  (Stat_Mispredict)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          kind;       // 0: lookup, 1: statistics
    logic [31:0] pc;
    logic        exp_taken;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic done   = 1'b0;

  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.kind == 0) begin
        n_cmp++;
        if (Predict_Taken_F !== mon_e.exp_taken) begin
          n_fail++;
          $display("FAIL taken pc=%h: got %b want %b", mon_e.pc, Predict_Taken_F, mon_e.exp_taken);
        end
        n_cmp++;
        if (Predict_Target_F !== mon_e.exp_a) begin
          n_fail++;
          $display("FAIL target pc=%h: got %h want %h", mon_e.pc, Predict_Target_F, mon_e.exp_a);
        end
      end
`ifdef BP_STATS_EN
      else begin
        n_cmp++;
        if (Stat_Resolved !== mon_e.exp_a) begin
          n_fail++;
          $display("FAIL stat_resolved: got %h want %h", Stat_Resolved, mon_e.exp_a);
        end
        n_cmp++;
        if (Stat_Mispredict !== mon_e.exp_b) begin
          n_fail++;
          $display("FAIL stat_mispredict: got %h want %h", Stat_Mispredict, mon_e.exp_b);
        end
      end
`endif
    end else if (done) begin
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want summary");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic look(input logic [31:0] pc, input logic taken, input logic [31:0] target);
    PC_F = pc;
    exp_q.push_back('{kind: 0, pc: pc, exp_taken: taken, exp_a: target, exp_b: 32'd0});
    step();
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic jump, input logic taken,
                         input logic [31:0] target, input logic pred);
    Update_En_E     = 1'b1;
    Jump_En_E       = jump;
    PC_E            = pc;
    Branch_Taken_E  = taken;
    PC_Target_E     = target;
    Predict_Taken_E = pred;
  endtask

  task automatic upd(input logic [31:0] pc, input logic jump, input logic taken,
                     input logic [31:0] target, input logic pred);
    set_upd(pc, jump, taken, target, pred);
    step();
    Update_En_E = 1'b0;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

`ifdef BP_STATS_EN
  task automatic stat_check(input logic [31:0] res, input logic [31:0] mis);
    exp_q.push_back('{kind: 1, pc: 32'd0, exp_taken: 1'b0, exp_a: res, exp_b: mis});
    step();
  endtask
`endif

  initial begin
    @(posedge CLK);
    #1;
    look(32'h40, 1'b0, 32'h0);            // outputs while reset is held
    RST = 1'b0;
    look(32'h40, 1'b0, 32'h0);

    // Allocate on taken miss: ctr WEAK_T
    upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b0);
    look(32'h40, 1'b1, 32'h100);
    look(32'h80, 1'b0, 32'h0);            // same index, different tag

    repeat (3) upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b1);
    upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b1); // 11 -> 10
    look(32'h40, 1'b1, 32'h100);
    upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b1); // 10 -> 01
    look(32'h40, 1'b0, 32'h0);
    upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b0); // 01 -> 00
    upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b0); // stays 00, entry still valid
    upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b0); // hit: 00 -> 01, no reallocation
    look(32'h40, 1'b0, 32'h0);

    upd(32'h44, 1'b1, 1'b1, 32'h200, 1'b0);
    look(32'h44, 1'b1, 32'h200);
    upd(32'h48, 1'b0, 1'b0, 32'h0, 1'b0);
    look(32'h48, 1'b0, 32'h0);

    // Aliased allocation replaces the entry at index 0
    upd(32'h80, 1'b0, 1'b1, 32'h300, 1'b0);
    look(32'h80, 1'b1, 32'h300);
    look(32'h83, 1'b1, 32'h300);          // low PC bits ignored
    look(32'h40, 1'b0, 32'h0);

    // Same-cycle update and lookup on an empty table
    pulse_reset();
    look(32'h44, 1'b0, 32'h0);
    set_upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b0);
    look(32'h40, 1'b0, 32'h0);
    Update_En_E = 1'b0;
    look(32'h40, 1'b1, 32'h100);

    // Reset asserted together with an update
    RST = 1'b1;
    set_upd(32'h48, 1'b0, 1'b1, 32'h400, 1'b0);
    step();
    RST = 1'b0;
    Update_En_E = 1'b0;
    look(32'h40, 1'b0, 32'h0);
    look(32'h48, 1'b0, 32'h0);

`ifdef BP_STATS_EN
    pulse_reset();
    stat_check(32'd0, 32'd0);
    upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b0); // mismatch
    upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b1);
    upd(32'h40, 1'b0, 1'b0, 32'h0,   1'b1); // mismatch
    upd(32'h44, 1'b1, 1'b1, 32'h200, 1'b1);
    upd(32'h48, 1'b0, 1'b0, 32'h0,   1'b0);
    stat_check(32'd5, 32'd2);
    force dut.u_stat_resolved.count_q   = 32'hFFFF_FFFF;
    force dut.u_stat_mispredict.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_stat_resolved.count_q;
    release dut.u_stat_mispredict.count_q;
    upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b0); // mismatch at saturation
    stat_check(32'hFFFF_FFFF, 32'hFFFF_FFFF);
`endif

    done = 1'b1;
  end

endmodule
`default_nettype wire
